// File: rtl/order_pkg.sv
// Shared definitions for the order gate controller.
// Holds the FSM state encoding, the side encoding and the default limit
// constants. The TLU top level and the bench use the same values.
package order_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COOLDOWN = 2'd2,
    HALT     = 2'd3
  } ord_state_e;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  localparam int PRICE_W          = 8;
  localparam int DEF_MAX_POS      = 4;
  localparam int DEF_COOLDOWN_CYC = 8;
  localparam int DEF_TIMEOUT_CYC  = 16;

endpackage

// File: rtl/order_gate_ctrl_if.sv
// Downstream order handshake bundle.
//   order_valid : an order is being presented
//   order_ready : downstream accepts the order in a cycle where valid is high
//   order_side  : 1 = buy, 0 = sell
//   order_price : latched price of the order
// master = order source (the gate controller), slave = order consumer.
interface order_gate_ctrl_if;
  import order_pkg::*;

  logic               order_valid;
  logic               order_ready;
  logic               order_side;
  logic [PRICE_W-1:0] order_price;

  modport master (
    output order_valid,
    output order_side,
    output order_price,
    input  order_ready
  );

  modport slave (
    input  order_valid,
    input  order_side,
    input  order_price,
    output order_ready
  );

endinterface

// File: rtl/order_gate_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock and synchronous active-high reset
//   inc      : add one this cycle (ignored once the counter is all-ones)
//   count    : current value, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/order_gate_ctrl.sv
// Order gate between the TLU decision output and the order interface.
// Samples a buy/sell decision when sig_valid pulses, applies position limits,
// a post-order cooldown, an order timeout and a kill switch, and presents
// accepted decisions as single orders over a valid/ready handshake.
//   clk, rst             : clock, synchronous active-high reset
//   sig_valid            : decision qualifier (one-cycle pulse)
//   buy_in, sell_in      : decision bits, sampled with sig_valid
//   price_in             : price sampled with the decision
//   kill                 : level kill switch, forces HALT while high
//   ord                  : order handshake (master side)
//   position             : signed net position
//   drop_count           : saturating count of dropped decisions and timeouts
//   state_o              : FSM state encoding for debug
module order_gate_ctrl
  import order_pkg::*;
#(
  parameter int MAX_POS      = DEF_MAX_POS,
  parameter int COOLDOWN_CYC = DEF_COOLDOWN_CYC,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int POS_W        = 8,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sig_valid,
  input  logic                     buy_in,
  input  logic                     sell_in,
  input  logic [PRICE_W-1:0]       price_in,
  input  logic                     kill,
  order_gate_ctrl_if.master        ord,
  output logic signed [POS_W-1:0]  position,
  output logic [CNT_W-1:0]         drop_count,
  output logic [1:0]               state_o
);

  localparam int CD_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'((COOLDOWN_CYC > 0) ? COOLDOWN_CYC - 1 : 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic signed [POS_W-1:0] POS_MAX = POS_W'(MAX_POS);
  localparam logic signed [POS_W-1:0] POS_MIN = -POS_MAX;
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);
  // With no cooldown a finished order returns straight to IDLE.
  localparam ord_state_e DONE_ST = (COOLDOWN_CYC > 0) ? COOLDOWN : IDLE;

  ord_state_e                state, state_nx;
  logic [CD_W-1:0]           cd_cnt, cd_cnt_nx;
  logic [TO_W-1:0]           to_cnt, to_cnt_nx;
  logic                      side_r, side_nx;
  logic [PRICE_W-1:0]        price_r, price_nx;
  logic signed [POS_W-1:0]   pos, pos_nx;
  logic                      has_dec;
  logic                      buy_ok;
  logic                      sell_ok;
  logic                      handshake;
  logic                      drop;

  assign has_dec   = sig_valid & (buy_in | sell_in);
  assign buy_ok    = buy_in & ~sell_in & (pos < POS_MAX);
  assign sell_ok   = sell_in & ~buy_in & (pos > POS_MIN);
  assign handshake = (state == ISSUE) & ord.order_ready;

  always_comb begin
    state_nx  = state;
    cd_cnt_nx = cd_cnt;
    to_cnt_nx = to_cnt;
    side_nx   = side_r;
    price_nx  = price_r;
    pos_nx    = pos;
    drop      = 1'b0;

    // Any decision arriving while busy or killed is lost.
    if (has_dec && ((state != IDLE) || kill)) begin
      drop = 1'b1;
    end

    case (state)
      IDLE: begin
        if (sig_valid && !kill) begin
          if (buy_ok || sell_ok) begin
            state_nx  = ISSUE;
            side_nx   = buy_ok ? SIDE_BUY : SIDE_SELL;
            price_nx  = price_in;
            to_cnt_nx = '0;
          end else if (has_dec) begin
            // conflict or limit reached
            drop = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (handshake) begin
          pos_nx    = (side_r == SIDE_BUY) ? pos + POS_ONE : pos - POS_ONE;
          state_nx  = DONE_ST;
          cd_cnt_nx = CD_LOAD;
          to_cnt_nx = '0;
        end else if (to_cnt == TO_LAST) begin
          drop      = 1'b1;
          state_nx  = DONE_ST;
          cd_cnt_nx = CD_LOAD;
          to_cnt_nx = '0;
        end else begin
          to_cnt_nx = to_cnt + TO_W'(1);
        end
      end
      COOLDOWN: begin
        if (cd_cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cd_cnt_nx = cd_cnt - CD_W'(1);
        end
      end
      HALT: begin
        cd_cnt_nx = '0;
        to_cnt_nx = '0;
        if (!kill) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Kill overrides the next state but a same-cycle handshake has already
    // updated the position above.
    if (kill) begin
      state_nx = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cd_cnt  <= '0;
      to_cnt  <= '0;
      side_r  <= 1'b0;
      price_r <= '0;
      pos     <= '0;
    end else begin
      state   <= state_nx;
      cd_cnt  <= cd_cnt_nx;
      to_cnt  <= to_cnt_nx;
      side_r  <= side_nx;
      price_r <= price_nx;
      pos     <= pos_nx;
    end
  end

  // Several drop sources in one cycle collapse into a single increment.
  sat_counter #(
    .W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop),
    .count (drop_count)
  );

  assign ord.order_valid = (state == ISSUE);
  assign ord.order_side  = side_r;
  assign ord.order_price = price_r;
  assign position        = pos;
  assign state_o         = state;

endmodule
